// File: rtl/bus_cycle_sequencer.sv
// Fixed-slot bus timing generator: 16-cycle frame, SPI slot (f 0-7) then CPU slot (f 8-15).
// Drives the slot owner's address to the decoder and turns decoder results into bus strobes.
module bus_cycle_sequencer (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [16:0] cpu_addr_i,
    input  logic        cpu_rw_i,
    input  logic        spi_req_i,
    input  logic [16:0] spi_addr_i,
    input  logic        spi_rw_i,
    output logic        spi_ack_o,
    output logic [7:0]  spi_rd_data_o,
    input  logic [7:0]  data_i,
    output logic [16:0] bus_addr_o,
    input  logic        ram_en_i,
    input  logic        io_en_i,
    input  logic        magic_en_i,
    input  logic        is_readonly_i,
    input  logic        is_mirrored_i,
    output logic [16:0] ram_addr_o,
    output logic        ram_oe_o,
    output logic        ram_we_o,
    output logic        io_strobe_o,
    output logic        magic_we_o,
    output logic        cpu_phi2_o
);

    logic [3:0]  frame_q;
    logic [2:0]  slot_cyc;
    logic        cpu_slot;

    logic [16:0] bus_addr_q;
    logic        rw_q;
    logic        active_q;

    logic        ram_oe_q, ram_oe_d;
    logic        ram_we_q, ram_we_d;
    logic        io_strobe_q, io_strobe_d;
    logic        magic_we_q, magic_we_d;
    logic        phi2_q, phi2_d;
    logic        spi_ack_q, spi_ack_d;
    logic [7:0]  rd_data_q;
    logic        rd_capture;

    logic        slot_rd;
    logic        slot_wr;
    logic        win_1_6;
    logic        win_2_5;

    assign slot_cyc = frame_q[2:0];
    assign cpu_slot = frame_q[3];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_q <= 4'd0;
        end else begin
            frame_q <= frame_q + 4'd1;
        end
    end

    // Owner's request is latched once per slot; later input changes wait for the next slot.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus_addr_q <= 17'd0;
            rw_q       <= 1'b0;
            active_q   <= 1'b0;
        end else if (slot_cyc == 3'd0) begin
            if (cpu_slot) begin
                bus_addr_q <= cpu_addr_i;
                rw_q       <= cpu_rw_i;
                active_q   <= 1'b1;
            end else begin
                bus_addr_q <= spi_addr_i;
                rw_q       <= spi_rw_i;
                active_q   <= spi_req_i;
            end
        end
    end

    always_comb begin
        slot_rd     = active_q & rw_q;
        slot_wr     = active_q & ~rw_q;
        win_1_6     = (slot_cyc >= 3'd1) && (slot_cyc <= 3'd6);
        win_2_5     = (slot_cyc >= 3'd2) && (slot_cyc <= 3'd5);

        ram_oe_d    = slot_rd & ram_en_i & win_1_6;
        // ROM is only write-protected against the CPU; SPI may load it.
        ram_we_d    = slot_wr & ram_en_i & win_2_5 & ~(cpu_slot & is_readonly_i);
        io_strobe_d = active_q & io_en_i & win_1_6;
        magic_we_d  = slot_wr & magic_en_i & (slot_cyc == 3'd6);
        spi_ack_d   = active_q & ~cpu_slot & (slot_cyc == 3'd7);
        rd_capture  = slot_rd & ~cpu_slot & (slot_cyc == 3'd6);
        // Registered, so decode one cycle early: high for CPU s=1..7.
        phi2_d      = (frame_q >= 4'd8) && (frame_q <= 4'd14);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ram_oe_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            io_strobe_q <= 1'b0;
            magic_we_q  <= 1'b0;
            phi2_q      <= 1'b0;
            spi_ack_q   <= 1'b0;
        end else begin
            ram_oe_q    <= ram_oe_d;
            ram_we_q    <= ram_we_d;
            io_strobe_q <= io_strobe_d;
            magic_we_q  <= magic_we_d;
            phi2_q      <= phi2_d;
            spi_ack_q   <= spi_ack_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= 8'd0;
        end else if (rd_capture) begin
            rd_data_q <= data_i;
        end
    end

    // 1 KB VRAM is mirrored across 8000-8FFF by dropping address bits 11:10.
    always_comb begin
        ram_addr_o = bus_addr_q;
        if (is_mirrored_i) begin
            ram_addr_o[11:10] = 2'b00;
        end
    end

    assign bus_addr_o    = bus_addr_q;
    assign ram_oe_o      = ram_oe_q;
    assign ram_we_o      = ram_we_q;
    assign io_strobe_o   = io_strobe_q;
    assign magic_we_o    = magic_we_q;
    assign cpu_phi2_o    = phi2_q;
    assign spi_ack_o     = spi_ack_q;
    assign spi_rd_data_o = rd_data_q;

endmodule
